// File: rtl/ld_st_unit_pkg.sv
// Shared MMIX load/store definitions: command struct, internal ops, opcodes,
// interrupt bit positions and the per-command transfer-size helpers.
package mmix_defs;

    typedef enum logic [3:0] {
        OP_LD       = 4'd0,
        OP_ST       = 4'd1,
        OP_INCGAMMA = 4'd2,
        OP_UNSAV    = 4'd3
    } int_op_e;

    typedef struct packed {
        int_op_e    i;
        logic [7:0] op;
        logic [7:0] xx;
        logic       x_global;
    } control_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_MEM  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [7:0] LDHT   = 8'h92;
    localparam logic [7:0] STHT   = 8'hB2;
    localparam logic [7:0] STCO   = 8'hB4;
    localparam logic [7:0] UNSAVE = 8'hFB;

    localparam int INT_W       = 19;
    localparam int INT_V       = 6;
    localparam int INT_ILLEGAL = 18;

    function automatic logic op_supported(input int_op_e i);
        return (i == OP_LD) || (i == OP_ST) || (i == OP_INCGAMMA) || (i == OP_UNSAV);
    endfunction

    // STCO stores its X field, so it does not wait for b.
    function automatic logic needs_b(input int_op_e i, input logic [7:0] op);
        return ((i == OP_ST) && (op != STCO)) || (i == OP_INCGAMMA);
    endfunction

    function automatic logic [1:0] xfer_size(input int_op_e i, input logic [7:0] op);
        logic [1:0] sz;
        sz = 2'd3;
        if (i == OP_LD) begin
            sz = (op == LDHT) ? 2'd2 : op[3:2];
        end else if (i == OP_ST) begin
            if (op == STHT)      sz = 2'd2;
            else if (op == STCO) sz = 2'd3;
            else                 sz = op[3:2];
        end
        return sz;
    endfunction

endpackage

// File: rtl/ld_st_unit_if.sv
// Memory request/done bus between the load/store unit and the memory system.
// Handshake: mem_read/mem_write is held with stable address, size and
// writedata until the first cycle mem_done is sampled high; mem_done is a
// one-cycle strobe and readdata is valid alongside it.
interface ld_st_unit_if;
    logic [63:0] mem_address;
    logic [1:0]  mem_datasize;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_readdata;
    logic [63:0] mem_writedata;
    logic        mem_done;

    modport master (
        output mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
        input  mem_readdata, mem_done
    );

    modport slave (
        input  mem_address, mem_datasize, mem_read, mem_write, mem_writedata,
        output mem_readdata, mem_done
    );
endinterface

// File: rtl/ld_st_unit_format.sv
// Combinational data formatting: load extension / LDHT shift on the read side,
// store truncation and signed-overflow detection on the write side.
module ld_st_format
    import mmix_defs::*;
(
    input  int_op_e     st_i,
    input  logic [7:0]  st_op,
    input  logic [7:0]  st_xx,
    input  logic [63:0] st_b,
    output logic [1:0]  st_size,
    output logic [63:0] st_wdata,
    output logic        st_ovf,
    input  int_op_e     ld_i,
    input  logic [7:0]  ld_op,
    input  logic [63:0] ld_rdata,
    output logic [63:0] ld_value
);

    function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] sz,
                                           input logic sgn);
        logic [63:0] r;
        case (sz)
            2'd0:    r = {{56{sgn & v[7]}},  v[7:0]};
            2'd1:    r = {{48{sgn & v[15]}}, v[15:0]};
            2'd2:    r = {{32{sgn & v[31]}}, v[31:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        st_size  = xfer_size(st_i, st_op);
        st_wdata = st_b;
        st_ovf   = 1'b0;
        if (st_i == OP_ST) begin
            if (st_op == STHT)      st_wdata = {32'd0, st_b[63:32]};
            else if (st_op == STCO) st_wdata = {56'd0, st_xx};
            else                    st_wdata = extend(st_b, st_size, 1'b0);
            // b fits a signed field exactly when sign-extending its truncation restores it.
            st_ovf = (st_op != STHT) && (st_op != STCO) && !st_op[1] && (st_size != 2'd3)
                     && (extend(st_b, st_size, 1'b1) != st_b);
        end
    end

    always_comb begin
        ld_value = ld_rdata;
        if (ld_i == OP_LD) begin
            if (ld_op == LDHT) ld_value = {ld_rdata[31:0], 32'd0};
            else               ld_value = extend(ld_rdata, ld_op[3:2], !ld_op[1]);
        end
    end

endmodule

// File: rtl/ld_st_unit.sv
// MMIX load/store unit: accept a command, wait for operands, run one memory
// transaction and write the formatted result back in a one-cycle DONE pulse.
module ld_st_unit
    import mmix_defs::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  control_t        data,
    input  logic [63:0]     y,
    input  logic [63:0]     z,
    input  logic [63:0]     b,
    input  logic            y_valid,
    input  logic            z_valid,
    input  logic            b_valid,
    output logic            gregwe,
    output logic            lregwe,
    output logic [7:0]      regwa,
    output logic [63:0]     regwd,
    ld_st_unit_if.master    mem,
    output logic            we_G,
    output logic [7:0]      new_G,
    output logic [INT_W-1:0] interrupt,
    output logic            done,
    output state_e          dbg_state
);

    state_e           state_q;
    control_t         cmd_q;
    logic             gregwe_q, lregwe_q, we_g_q, done_q;
    logic             mem_read_q, mem_write_q, ovf_q;
    logic [7:0]       regwa_q, new_g_q;
    logic [63:0]      regwd_q, mem_address_q, mem_writedata_q;
    logic [1:0]       mem_datasize_q;
    logic [INT_W-1:0] interrupt_q;

    // In IDLE the command is still on the input; afterwards it lives in cmd_q.
    control_t    cmd_d;
    logic        ops_ready;
    logic [63:0] ea, align_mask, st_wdata, ld_value;
    logic [1:0]  st_size;
    logic        st_ovf;

    always_comb begin
        cmd_d     = (state_q == S_IDLE) ? data : cmd_q;
        ops_ready = y_valid && z_valid && (b_valid || !needs_b(cmd_d.i, cmd_d.op));
        ea        = y + z;
        case (st_size)
            2'd0:    align_mask = ~64'h0;
            2'd1:    align_mask = ~64'h1;
            2'd2:    align_mask = ~64'h3;
            default: align_mask = ~64'h7;
        endcase
    end

    ld_st_format u_format (
        .st_i     (cmd_d.i),
        .st_op    (cmd_d.op),
        .st_xx    (cmd_d.xx),
        .st_b     (b),
        .st_size  (st_size),
        .st_wdata (st_wdata),
        .st_ovf   (st_ovf),
        .ld_i     (cmd_q.i),
        .ld_op    (cmd_q.op),
        .ld_rdata (mem.mem_readdata),
        .ld_value (ld_value)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            cmd_q           <= '0;
            gregwe_q        <= 1'b0;
            lregwe_q        <= 1'b0;
            we_g_q          <= 1'b0;
            done_q          <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            ovf_q           <= 1'b0;
            regwa_q         <= '0;
            new_g_q         <= '0;
            regwd_q         <= '0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            mem_datasize_q  <= '0;
            interrupt_q     <= '0;
        end else begin
            done_q      <= 1'b0;
            gregwe_q    <= 1'b0;
            lregwe_q    <= 1'b0;
            we_g_q      <= 1'b0;
            interrupt_q <= '0;
            case (state_q)
                S_IDLE, S_WAIT: begin
                    if (state_q == S_IDLE && enable) begin
                        cmd_q   <= data;
                        regwa_q <= data.xx;
                    end
                    if (state_q == S_IDLE && enable && !op_supported(data.i)) begin
                        done_q                   <= 1'b1;
                        interrupt_q[INT_ILLEGAL] <= 1'b1;
                        state_q                  <= S_DONE;
                    end else if ((state_q == S_WAIT || enable) && ops_ready) begin
                        mem_address_q   <= ea & align_mask;
                        mem_datasize_q  <= st_size;
                        mem_writedata_q <= st_wdata;
                        ovf_q           <= st_ovf;
                        mem_read_q      <= (cmd_d.i == OP_LD) || (cmd_d.i == OP_UNSAV);
                        mem_write_q     <= (cmd_d.i == OP_ST) || (cmd_d.i == OP_INCGAMMA);
                        state_q         <= S_MEM;
                    end else if (state_q == S_IDLE && enable) begin
                        state_q <= S_WAIT;
                    end
                end
                S_MEM: begin
                    if (mem.mem_done) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                        case (cmd_q.i)
                            OP_LD: begin
                                regwd_q  <= ld_value;
                                gregwe_q <= cmd_q.x_global;
                                lregwe_q <= !cmd_q.x_global;
                            end
                            OP_ST: interrupt_q[INT_V] <= ovf_q;
                            OP_UNSAV: begin
                                if (cmd_q.xx != 8'd0) begin
                                    regwd_q  <= ld_value;
                                    gregwe_q <= cmd_q.x_global;
                                    lregwe_q <= !cmd_q.x_global;
                                end else begin
                                    we_g_q  <= 1'b1;
                                    new_g_q <= mem.mem_readdata[63:56];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gregwe             = gregwe_q;
    assign lregwe             = lregwe_q;
    assign regwa              = regwa_q;
    assign regwd              = regwd_q;
    assign we_G               = we_g_q;
    assign new_G              = new_g_q;
    assign interrupt          = interrupt_q;
    assign done               = done_q;
    assign dbg_state          = state_q;
    assign mem.mem_address    = mem_address_q;
    assign mem.mem_datasize   = mem_datasize_q;
    assign mem.mem_read       = mem_read_q;
    assign mem.mem_write      = mem_write_q;
    assign mem.mem_writedata  = mem_writedata_q;

endmodule

// File: tb/tb_ld_st_unit.sv
// Directed bench for ld_st_unit: hand-computed vectors for each command class,
// illegal op and mid-transaction reset.
module tb_ld_st_unit;
    import mmix_defs::*;

    logic             clk;
    logic             reset_n;
    logic             enable;
    control_t         data;
    logic [63:0]      y, z, b;
    logic             y_valid, z_valid, b_valid;
    logic             gregwe, lregwe, we_G, done;
    logic [7:0]       regwa, new_G;
    logic [63:0]      regwd;
    logic [INT_W-1:0] interrupt;
    state_e           dbg_state;

    ld_st_unit_if mem_bus ();

    ld_st_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .data      (data),
        .y         (y),
        .z         (z),
        .b         (b),
        .y_valid   (y_valid),
        .z_valid   (z_valid),
        .b_valid   (b_valid),
        .gregwe    (gregwe),
        .lregwe    (lregwe),
        .regwa     (regwa),
        .regwd     (regwd),
        .mem       (mem_bus),
        .we_G      (we_G),
        .new_G     (new_G),
        .interrupt (interrupt),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic control_t mk(input int_op_e i, input logic [7:0] op,
                                    input logic [7:0] xx, input logic xg);
        control_t c;
        c.i = i;
        c.op = op;
        c.xx = xx;
        c.x_global = xg;
        return c;
    endfunction

    // driver: present a command with its operands for one enable cycle
    task automatic start(input control_t c, input logic [63:0] yv, zv, bv,
                         input logic yok, zok, bok);
        data = c;
        y = yv; z = zv; b = bv;
        y_valid = yok; z_valid = zok; b_valid = bok;
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    // driver: pulse mem_done with readdata, landing in the DONE cycle
    task automatic complete(input string tag, input logic [63:0] rdata);
        mem_bus.mem_readdata = rdata;
        mem_bus.mem_done = 1'b1;
        tick();
        mem_bus.mem_done = 1'b0;
        check({tag, "_done"}, done, 1);
    endtask

    // scoreboard: load result expected at DONE
    task automatic check_regwd(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: got empty expected queue required one entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_regwd"}, regwd, e);
        end
    endtask

    task automatic idle_operands;
        y_valid = 1'b0; z_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"},   done, 0);
        check({tag, "_rd_wr"},  {mem_bus.mem_read, mem_bus.mem_write}, 0);
        check({tag, "_addr"},   mem_bus.mem_address, 0);
        check({tag, "_wdata"},  mem_bus.mem_writedata, 0);
        check({tag, "_size"},   mem_bus.mem_datasize, 0);
        check({tag, "_regwe"},  {gregwe, lregwe, we_G}, 0);
        check({tag, "_regwa"},  regwa, 0);
        check({tag, "_regwd"},  regwd, 0);
        check({tag, "_newg"},   new_G, 0);
        check({tag, "_intr"},   interrupt, 0);
        check({tag, "_state"},  dbg_state, S_IDLE);
    endtask

    initial begin
        reset_n = 1'b0;
        enable = 1'b0;
        data = '0;
        y = '0; z = '0; b = '0;
        idle_operands();
        mem_bus.mem_readdata = '0;
        mem_bus.mem_done = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // incgamma: z/b arrive one cycle late, mem_done two cycles into MEM
        start(mk(OP_INCGAMMA, 8'h00, 8'd0, 1'b0), 64'd10, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        check("incg_wait_norq", mem_bus.mem_write, 0);
        z = 64'd32; b = 64'h1234; z_valid = 1'b1; b_valid = 1'b1;
        tick();
        check("incg_write", mem_bus.mem_write, 1);
        check("incg_read",  mem_bus.mem_read, 0);
        check("incg_addr",  mem_bus.mem_address, 64'd40);
        check("incg_size",  mem_bus.mem_datasize, 3);
        check("incg_wdata", mem_bus.mem_writedata, 64'h1234);
        tick();
        check("incg_hold", mem_bus.mem_write, 1);
        complete("incg", 64'd0);
        check("incg_regwe", {gregwe, lregwe, we_G}, 0);
        check("incg_intr", interrupt, 0);
        tick();
        check("incg_pulse", done, 0);
        idle_operands();

        // unsav final step restores G
        start(mk(OP_UNSAV, UNSAVE, 8'd0, 1'b0), 64'd1, 64'd16, 64'd0, 1'b1, 1'b1, 1'b0);
        check("unsav_read", mem_bus.mem_read, 1);
        check("unsav_addr", mem_bus.mem_address, 64'd16);
        complete("unsav", 64'h2000_0000_0000_FFFF);
        check("unsav_weg", we_G, 1);
        check("unsav_newg", new_G, 8'h20);
        check("unsav_regwe", {gregwe, lregwe}, 0);
        tick();

        // LDB signed into local file
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FF80);
        start(mk(OP_LD, 8'h80, 8'd5, 1'b0), 64'h100, 64'd3, 64'd0, 1'b1, 1'b1, 1'b0);
        check("ldb_addr", mem_bus.mem_address, 64'h103);
        check("ldb_size", mem_bus.mem_datasize, 0);
        complete("ldb", 64'h80);
        check("ldb_lregwe", {gregwe, lregwe}, 2'b01);
        check("ldb_regwa", regwa, 8'd5);
        check_regwd("ldb");
        tick();

        // LDBU zero-extends
        exp_q.push_back(64'h80);
        start(mk(OP_LD, 8'h82, 8'd5, 1'b0), 64'h100, 64'd3, 64'd0, 1'b1, 1'b1, 1'b0);
        complete("ldbu", 64'h80);
        check_regwd("ldbu");
        tick();

        // LDHT into global file
        exp_q.push_back(64'h1234_5678_0000_0000);
        start(mk(OP_LD, LDHT, 8'd200, 1'b1), 64'h200, 64'd6, 64'd0, 1'b1, 1'b1, 1'b0);
        check("ldht_addr", mem_bus.mem_address, 64'h204);
        check("ldht_size", mem_bus.mem_datasize, 2);
        complete("ldht", 64'h1234_5678);
        check("ldht_gregwe", {gregwe, lregwe}, 2'b10);
        check_regwd("ldht");
        tick();

        // STB overflow still stores the low byte
        start(mk(OP_ST, 8'hA0, 8'd1, 1'b0), 64'h10, 64'd1, 64'h180, 1'b1, 1'b1, 1'b1);
        check("stb_write", mem_bus.mem_write, 1);
        check("stb_wdata", mem_bus.mem_writedata, 64'h80);
        check("stb_addr", mem_bus.mem_address, 64'h11);
        complete("stb", 64'd0);
        check("stb_intr", interrupt, 64'h40);
        check("stb_regwe", {gregwe, lregwe, we_G}, 0);
        tick();

        // STBU: no overflow check
        start(mk(OP_ST, 8'hA2, 8'd1, 1'b0), 64'h10, 64'd1, 64'h180, 1'b1, 1'b1, 1'b1);
        complete("stbu", 64'd0);
        check("stbu_intr", interrupt, 0);
        tick();

        // STCO needs no b and stores xx as an octa
        start(mk(OP_ST, STCO, 8'h7F, 1'b0), 64'h20, 64'd5, 64'hDEAD, 1'b1, 1'b1, 1'b0);
        check("stco_write", mem_bus.mem_write, 1);
        check("stco_wdata", mem_bus.mem_writedata, 64'h7F);
        check("stco_size", mem_bus.mem_datasize, 3);
        check("stco_addr", mem_bus.mem_address, 64'h20);
        complete("stco", 64'd0);
        check("stco_intr", interrupt, 0);
        tick();

        // unsupported internal op
        start(mk(int_op_e'(4'd9), 8'h00, 8'd0, 1'b0), 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 1'b1);
        check("ill_done", done, 1);
        check("ill_intr", interrupt, 64'h40000);
        check("ill_norq", {mem_bus.mem_read, mem_bus.mem_write}, 0);
        tick();
        check("ill_pulse", done, 0);

        // reset while in MEM drops everything at once
        start(mk(OP_LD, 8'h80, 8'd5, 1'b1), 64'h100, 64'd3, 64'd0, 1'b1, 1'b1, 1'b0);
        check("rst_pre_read", mem_bus.mem_read, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tick();
        reset_n = 1'b1;
        tick();
        exp_q.push_back(64'h80);
        start(mk(OP_LD, 8'h82, 8'd9, 1'b0), 64'h100, 64'd3, 64'd0, 1'b1, 1'b1, 1'b0);
        check("rst_post_read", mem_bus.mem_read, 1);
        complete("rst_post", 64'h80);
        check("rst_post_regwa", regwa, 8'd9);
        check_regwd("rst_post");
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

endmodule
